// File: rtl/spike_packetizer.sv
// Turns per-neuron fire pulses into destination packets streamed as flits, LS flit first; spike-to-flit0 is 2 edges.
// router_full stalls the flit stream in place; spikes arriving meanwhile accumulate in the pending register.
module spike_packetizer #(
  parameter int packet_size          = 32,
  parameter int flit_size            = 4,
  parameter int x_address_length     = 8,
  parameter int y_address_length     = 8,
  parameter int AXON_CNT_BIT_WIDTH   = 1,
  parameter int NUM_NEURONS          = 4,
  parameter int NEURON_CNT_BIT_WIDTH = 2
) (
  input  logic                                                             neuron_clk,
  input  logic                                                             rst_n,
  input  logic [NUM_NEURONS-1:0]                                           spike_in,
  input  logic                                                             cfg_we,
  input  logic [NEURON_CNT_BIT_WIDTH-1:0]                                  cfg_addr,
  input  logic [x_address_length+y_address_length+AXON_CNT_BIT_WIDTH-1:0] cfg_data,
  input  logic                                                             router_full,
  output logic [flit_size-1:0]                                             flit_out,
  output logic                                                             flit_valid,
  output logic                                                             busy
);

  localparam int FLITS   = packet_size / flit_size;
  localparam int ENTRY_W = x_address_length + y_address_length + AXON_CNT_BIT_WIDTH;
  localparam int CNT_W   = (FLITS > 1) ? $clog2(FLITS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state_q, state_d;
  logic [NUM_NEURONS-1:0]          pending_q, pending_d, clear;
  logic [packet_size-1:0]          shift_q, shift_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NEURON_CNT_BIT_WIDTH-1:0] last_q, last_d, sel_idx, cand;
  logic                            sel_found;
  logic [ENTRY_W-1:0]              table_q [NUM_NEURONS];

  // Round-robin search begins one past the neuron served most recently.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= NUM_NEURONS; k++) begin
      cand = NEURON_CNT_BIT_WIDTH'((int'(last_q) + k) % NUM_NEURONS);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign flit_valid = (state_q == SEND) && !router_full;
  assign flit_out   = shift_q[flit_size-1:0];
  assign busy       = (state_q == SEND) || (|pending_q);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    clear   = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          shift_d        = packet_size'(table_q[sel_idx]);
          cnt_d          = '0;
          last_d         = sel_idx;
          clear[sel_idx] = 1'b1;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (flit_valid) begin
          shift_d = shift_q >> flit_size;
          if (cnt_q == CNT_W'(FLITS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A spike landing on the clearing edge re-arms the bit for another packet.
    pending_d = (pending_q & ~clear) | spike_in;
  end

  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      last_q    <= NEURON_CNT_BIT_WIDTH'(NUM_NEURONS - 1);
      for (int i = 0; i < NUM_NEURONS; i++) table_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (cfg_we && cfg_addr == NEURON_CNT_BIT_WIDTH'(i)) table_q[i] <= cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_spike_packetizer.sv
// Bench for spike_packetizer: vector table, directed corner sequences, flit scoreboard on the output.
module tb_spike_packetizer;

  logic        neuron_clk;
  logic        rst_n;
  logic [3:0]  spike_in;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [16:0] cfg_data;
  logic        router_full;
  logic [3:0]  flit_out;
  logic        flit_valid;
  logic        busy;

  spike_packetizer dut (
    .neuron_clk (neuron_clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .router_full(router_full),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .busy       (busy)
  );

  initial neuron_clk = 1'b0;
  always #5 neuron_clk = ~neuron_clk;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [1:0]  n;
    logic        axon;
    logic [7:0]  y;
    logic [7:0]  x;
    logic [31:0] pkt;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input logic [31:0] pkt);
    for (int i = 0; i < 8; i++) exp_q.push_back(pkt[i*4 +: 4]);
  endtask

  task automatic step();
    @(posedge neuron_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [16:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("wait_idle_timeout", (n >= budget) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Every transferred flit must be the next one the scoreboard expects.
  always @(negedge neuron_clk) begin
    if (flit_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_flit", {28'd0, flit_out}, 32'hDEAD);
      else chk("flit_data", {28'd0, flit_out}, {28'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd2, 1'b1, 8'h05, 8'h03, 32'h0001_0503};
    vecs[1] = '{2'd0, 1'b0, 8'hAB, 8'hCD, 32'h0000_ABCD};
    vecs[2] = '{2'd3, 1'b1, 8'hFF, 8'h00, 32'h0001_FF00};
    vecs[3] = '{2'd1, 1'b1, 8'h12, 8'h34, 32'h0001_1234};

    rst_n = 1'b0; spike_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; router_full = 1'b0;
    #3;
    chk("rst_flit_valid", flit_valid, 0);
    chk("rst_flit_out", flit_out, 0);
    chk("rst_busy", busy, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Vector table: single packet, exact latency, 8 back-to-back flits, busy drops after.
    for (int v = 0; v < 4; v++) begin
      cfg_write(vecs[v].n, {vecs[v].axon, vecs[v].y, vecs[v].x});
      spike_in = '0;
      spike_in[vecs[v].n] = 1'b1;
      push_pkt(vecs[v].pkt);
      step();
      spike_in = '0;
      @(negedge neuron_clk);
      chk("pend_busy", busy, 1);
      chk("pend_valid", flit_valid, 0);
      for (int f = 0; f < 8; f++) begin
        step();
        @(negedge neuron_clk);
        chk("valid_run", flit_valid, 1);
      end
      step();
      @(negedge neuron_clk);
      chk("done_busy", busy, 0);
      chk("done_valid", flit_valid, 0);
      chk("done_queue", exp_q.size(), 0);
      step();
    end

    // Backpressure on flit 4, with a table write on the latch edge.
    spike_in = 4'b0100;
    push_pkt(32'h0001_0503);
    step();
    spike_in = '0;
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = {1'b0, 8'h77, 8'h66};
    step();
    cfg_we = 1'b0;
    repeat (4) step();
    router_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge neuron_clk);
      chk("stall_valid", flit_valid, 0);
      chk("stall_flit_out", {28'd0, flit_out}, 32'd1);
      chk("stall_busy", busy, 1);
      step();
    end
    router_full = 1'b0;
    wait_idle(40);
    spike_in = 4'b0100;
    push_pkt(32'h0000_7766);
    step();
    spike_in = '0;
    wait_idle(40);

    // All four neurons at once from reset: order 0..3, one idle cycle between packets.
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    cfg_write(2'd0, {1'b0, 8'h11, 8'h22});
    cfg_write(2'd1, {1'b1, 8'h33, 8'h44});
    cfg_write(2'd2, {1'b0, 8'h55, 8'h66});
    cfg_write(2'd3, {1'b1, 8'hAA, 8'hBB});
    spike_in = 4'b1111;
    push_pkt(32'h0000_1122);
    push_pkt(32'h0001_3344);
    push_pkt(32'h0000_5566);
    push_pkt(32'h0001_AABB);
    step();
    spike_in = '0;
    @(negedge neuron_clk);
    chk("all_pend_valid", flit_valid, 0);
    for (int k = 0; k < 35; k++) begin
      @(posedge neuron_clk);
      @(negedge neuron_clk);
      chk("all_valid_pattern", flit_valid, (k % 9 != 8) ? 32'd1 : 32'd0);
    end
    @(posedge neuron_clk);
    @(negedge neuron_clk);
    chk("all_done_busy", busy, 0);
    chk("all_done_queue", exp_q.size(), 0);
    step();

    // Three neuron-1 pulses during a neuron-0 packet merge into one packet.
    spike_in = 4'b0001;
    push_pkt(32'h0000_1122);
    push_pkt(32'h0001_3344);
    step();
    spike_in = '0;
    for (int p = 0; p < 3; p++) begin
      step(); step();
      spike_in = 4'b0010;
      step();
      spike_in = '0;
    end
    wait_idle(60);
    repeat (5) step();
    chk("merge_busy", busy, 0);

    // Neuron 0 fires again on the edge its pending bit is cleared: two packets.
    spike_in = 4'b0001;
    push_pkt(32'h0000_1122);
    push_pkt(32'h0000_1122);
    step();
    step();
    spike_in = '0;
    wait_idle(60);
    repeat (5) step();
    chk("refire_busy", busy, 0);

    // Reset while flit 3 is presented abandons the packet.
    spike_in = 4'b0010;
    push_pkt(32'h0001_3344);
    step();
    spike_in = '0;
    repeat (4) step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", flit_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_flit_out", flit_out, 0);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("post_rst_busy", busy, 0);
    spike_in = 4'b0010;
    push_pkt(32'h0000_0000);
    step();
    spike_in = '0;
    wait_idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
